// File: rtl/param_updown_counter.sv
// param_updown_counter
// Parametrised up/down counter with parallel load, programmable step and
// terminal limit, and three boundary modes (wrap, saturate, one-shot).
// Produces a registered one-cycle terminal-count pulse (tc) and a one-shot
// done level.
// Optional snapshot register enabled by the macro PARAM_UPDOWN_COUNTER_CAPTURE_EN;
// without it capture_value is constant zero and no register is built.
module param_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              enable,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              done,
    input  logic              capture,
    output logic [WIDTH-1:0]  capture_value
);

    localparam int EW = WIDTH + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
    state_t           state_reg, state_next;

    // Boundary arithmetic is carried one bit wider than the count so that
    // count+step and count+limit+1 never lose their carry.
    logic [EW-1:0]    count_ext;
    logic [EW-1:0]    step_ext;
    logic [EW-1:0]    limit_ext;
    logic [EW-1:0]    limit_p1;
    logic [EW-1:0]    sum_up;
    logic [EW-1:0]    wrap_up;
    logic [EW-1:0]    wrap_dn;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] diff_dn;
    logic [WIDTH-1:0] wrap_up_val;
    logic [WIDTH-1:0] wrap_dn_val;
    logic [WIDTH-1:0] load_clamped;
    logic             above_limit;
    logic             up_ovf;
    logic             dn_unf;
    logic             mode_sat;
    logic             mode_one;

    assign count_ext = {1'b0, count_reg};
    assign step_ext  = EW'(step);
    assign step_w    = WIDTH'(step);
    assign limit_ext = {1'b0, limit};
    assign limit_p1  = limit_ext + EW'(1);

    assign sum_up  = count_ext + step_ext;
    assign wrap_up = sum_up - limit_p1;
    // May go "negative" (huge modulo value) when limit is small; the
    // range check below then clamps it to limit.
    assign wrap_dn = count_ext + limit_p1 - step_ext;
    assign diff_dn = count_reg - step_w;

    assign wrap_up_val  = (wrap_up > limit_ext) ? '0 : wrap_up[WIDTH-1:0];
    assign wrap_dn_val  = (wrap_dn > limit_ext) ? limit : wrap_dn[WIDTH-1:0];
    assign load_clamped = (load_value > limit) ? limit : load_value;

    // A count stranded above a lowered limit is always a boundary case.
    assign above_limit = (count_ext > limit_ext);
    assign up_ovf      = above_limit || (sum_up > limit_ext);
    assign dn_unf      = (step_ext > count_ext);

    // Reserved mode 11 falls through to wrap.
    assign mode_sat = (mode == 2'b01);
    assign mode_one = (mode == 2'b10);

    // Next-state / next-count decode: load beats enable; DONE ignores enable.
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        state_next = state_reg;
        if (load) begin
            count_next = load_clamped;
            state_next = ST_RUN;
        end else if (enable && (state_reg == ST_RUN) && (step != '0)) begin
            if (dir) begin
                if (up_ovf) begin
                    if (mode_sat) begin
                        count_next = limit;
                        tc_next    = (count_reg != limit);
                    end else if (mode_one) begin
                        count_next = limit;
                        tc_next    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        count_next = wrap_up_val;
                        tc_next    = 1'b1;
                    end
                end else begin
                    count_next = sum_up[WIDTH-1:0];
                end
            end else begin
                if (above_limit) begin
                    count_next = limit;
                end else if (dn_unf) begin
                    if (mode_sat) begin
                        count_next = '0;
                        tc_next    = (count_reg != '0);
                    end else if (mode_one) begin
                        count_next = '0;
                        tc_next    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        count_next = wrap_dn_val;
                        tc_next    = 1'b1;
                    end
                end else begin
                    count_next = diff_dn;
                end
            end
        end
    end

    // State, count and tc registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            state_reg <= ST_RUN;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            state_reg <= state_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign done  = (state_reg == ST_DONE);

`ifdef PARAM_UPDOWN_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] capture_value_reg;

    // Snapshot of the pre-update count; only reset outranks the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_value_reg <= '0;
        end else if (capture) begin
            capture_value_reg <= count_reg;
        end
    end

    assign capture_value = capture_value_reg;
`else
    // Constant zero; capture is folded in only so the port is not dangling.
    assign capture_value = {WIDTH{1'b0}} & {WIDTH{capture}};
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=8, STEP_W=4).
// A behavioural model predicts each cycle; predictions are queued when the
// stimulus is driven and popped when the registered outputs settle.
module tb_param_updown_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic [WIDTH-1:0]  load_value = '0;
    logic              enable = 1'b0;
    logic              dir = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic [WIDTH-1:0]  limit = '0;
    logic [1:0]        mode = '0;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              done;
    logic              capture = 1'b0;
    logic [WIDTH-1:0]  capture_value;

    param_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .enable(enable), .dir(dir), .step(step), .limit(limit), .mode(mode),
        .count(count), .tc(tc), .done(done),
        .capture(capture), .capture_value(capture_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             done;
        logic [WIDTH-1:0] cap;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int m_count = 0;
    bit m_tc    = 0;
    bit m_done  = 0;
    int m_cap   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model_step(input bit rst, input bit ld, input int lv, input bit en,
                              input bit d, input int s, input int lim, input int md,
                              input bit cap);
        int r;
        if (rst) begin
            m_count = 0; m_tc = 0; m_done = 0; m_cap = 0;
            return;
        end
`ifdef PARAM_UPDOWN_COUNTER_CAPTURE_EN
        if (cap) m_cap = m_count;
`endif
        m_tc = 0;
        if (ld) begin
            m_count = (lv > lim) ? lim : lv;
            m_done  = 0;
        end else if (en && !m_done && s != 0) begin
            if (d) begin
                if (m_count > lim || m_count + s > lim) begin
                    if (md == 1) begin
                        m_tc = (m_count != lim);
                        m_count = lim;
                    end else if (md == 2) begin
                        m_count = lim; m_tc = 1; m_done = 1;
                    end else begin
                        r = m_count + s - (lim + 1);
                        m_count = (r > lim) ? 0 : r;
                        m_tc = 1;
                    end
                end else begin
                    m_count = m_count + s;
                end
            end else begin
                if (m_count > lim) begin
                    m_count = lim;
                end else if (s > m_count) begin
                    if (md == 1) begin
                        m_tc = (m_count != 0);
                        m_count = 0;
                    end else if (md == 2) begin
                        m_count = 0; m_tc = 1; m_done = 1;
                    end else begin
                        r = m_count + lim + 1 - s;
                        m_count = (r < 0 || r > lim) ? lim : r;
                        m_tc = 1;
                    end
                end else begin
                    m_count = m_count - s;
                end
            end
        end
    endtask

    // One clock: drive at negedge, predict, push; compare after posedge.
    task automatic cyc(input string name, input bit rst, input bit ld, input int lv,
                       input bit en, input bit d, input int s, input int lim,
                       input int md, input bit cap);
        exp_t e;
        exp_t o;
        @(negedge clk);
        reset = rst; load = ld; load_value = lv[WIDTH-1:0]; enable = en; dir = d;
        step = s[STEP_W-1:0]; limit = lim[WIDTH-1:0]; mode = md[1:0]; capture = cap;
        model_step(rst, ld, lv, en, d, s, lim, md, cap);
        e.count = m_count[WIDTH-1:0];
        e.tc    = m_tc;
        e.done  = m_done;
        e.cap   = m_cap[WIDTH-1:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        $display("[%0t] %s rst=%0d ld=%0d en=%0d dir=%0d step=%0d lim=%0d mode=%0d -> count=%0d tc=%0d done=%0d cap=%0d",
                 $time, name, rst, ld, en, d, s, lim, md, count, tc, done, capture_value);
        check_val({name, "_count"}, count, o.count);
        check_val({name, "_tc"}, tc, o.tc);
        check_val({name, "_done"}, done, o.done);
        check_val({name, "_cap"}, capture_value, o.cap);
    endtask

    initial begin
        // reset state
        cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("rst_lit_count", count, 0);

        // wrap up, step 3, limit 9: 3,6,9,2 (tc on 2)
        cyc("tp1_ld", 0, 1, 0, 0, 1, 3, 9, 0, 0);
        for (int i = 0; i < 4; i++) cyc("tp1", 0, 0, 0, 1, 1, 3, 9, 0, 0);
        check_val("tp1_lit_count", count, 2);
        check_val("tp1_lit_tc", tc, 1);

        // saturate down, step 4 from 6: 2,0,0 (tc only at first 0)
        cyc("tp2_ld", 0, 1, 6, 0, 0, 4, 9, 1, 0);
        for (int i = 0; i < 3; i++) cyc("tp2", 0, 0, 0, 1, 0, 4, 9, 1, 0);
        check_val("tp2_lit_tc", tc, 0);

        // one-shot up, step 1, limit 3 from 1
        cyc("tp3_ld", 0, 1, 1, 0, 1, 1, 3, 2, 0);
        for (int i = 0; i < 4; i++) cyc("tp3", 0, 0, 0, 1, 1, 1, 3, 2, 0);
        check_val("tp3_lit_done", done, 1);
        cyc("tp3_mode", 0, 0, 0, 1, 1, 1, 3, 0, 0);     // mode change stays DONE
        cyc("tp3_reld", 0, 1, 0, 1, 1, 1, 3, 2, 0);
        check_val("tp3_lit_done0", done, 0);
        for (int i = 0; i < 2; i++) cyc("tp3_run", 0, 0, 0, 1, 1, 1, 3, 2, 0);

        // load clamp, load beats enable, reset beats both
        cyc("ldclamp", 0, 1, 200, 0, 1, 1, 100, 0, 0);
        check_val("ldclamp_lit", count, 100);
        cyc("ldwin", 0, 1, 5, 1, 1, 3, 100, 0, 0);
        cyc("rstwin", 1, 1, 7, 1, 1, 3, 100, 0, 0);

        // reset while DONE
        cyc("os_ld", 0, 1, 2, 0, 0, 3, 20, 2, 0);
        cyc("os_dn", 0, 0, 0, 1, 0, 3, 20, 2, 0);
        cyc("os_rst", 1, 0, 0, 1, 0, 3, 20, 2, 0);

        // limit lowered below count in wrap up
        cyc("low_ld", 0, 1, 30, 0, 1, 1, 50, 0, 0);
        cyc("low", 0, 0, 0, 1, 1, 1, 10, 0, 0);
        check_val("low_lit_count", count, 0);
        check_val("low_lit_tc", tc, 1);

        // limit = 0 in each mode, plus step 0 hold
        for (int md = 0; md < 3; md++) begin
            cyc("l0_ld", 0, 1, 9, 0, 1, 1, 0, md, 0);
            cyc("l0_up", 0, 0, 0, 1, 1, 2, 0, md, 0);
            cyc("l0_dn", 0, 0, 0, 1, 0, 3, 0, md, 0);
        end
        cyc("s0_ld", 0, 1, 4, 0, 1, 0, 9, 0, 0);
        cyc("s0", 0, 0, 0, 1, 1, 0, 9, 0, 0);
        cyc("wdn_ld", 0, 1, 1, 0, 0, 5, 2, 3, 0);
        cyc("wdn", 0, 0, 0, 1, 0, 5, 2, 3, 0);

        // capture of pre-update count
        cyc("cap_ld", 0, 1, 5, 0, 1, 1, 50, 0, 0);
        cyc("cap", 0, 0, 0, 1, 1, 1, 50, 0, 1);
        check_val("cap_lit_count", count, 6);
`ifdef PARAM_UPDOWN_COUNTER_CAPTURE_EN
        check_val("cap_lit_value", capture_value, 5);
`else
        check_val("cap_lit_value", capture_value, 0);
`endif

        // randomised traffic
        begin
            int lim = 40;
            for (int i = 0; i < 400; i++) begin
                if (i % 16 == 0) lim = $urandom_range(0, 255);
                cyc("rnd", ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 255), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 1), $urandom_range(0, 15), lim,
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
